// File: rtl/sub_64_seq_pkg.sv
// ============================================================================
// Module      : sub_64_seq_pkg
// Description : Shared constants and FSM state encoding for the sequential
//               64-bit subtractor (sub_64_seq) and its slice datapath.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sub_64_seq_pkg;

  // Operand / result width of the subtractor.
  localparam int DATA_W          = 64;

  // Default number of bits processed per BUSY cycle.
  localparam int SLICE_W_DEFAULT = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : sub_64_seq_pkg

`default_nettype wire

// File: rtl/sub_slice.sv
// ============================================================================
// Module      : sub_slice
// Description : SLICE_W-bit ripple of full-adder cells computing
//               a + b_n + cin. The caller supplies the already inverted
//               subtrahend, so chaining slices with an initial carry of 1
//               yields a two's-complement subtraction.
// Ports       : a     - minuend slice
//               b_n   - inverted subtrahend slice
//               cin   - carry into bit 0
//               sum   - slice sum
//               cout  - carry out of the top bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b_n,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  // c[i] is the carry into bit i; c[SLICE_W] leaves the slice.
  logic [SLICE_W:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < SLICE_W; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b_n[i] ^ c[i];
      assign c[i + 1] = (a[i] & b_n[i]) | (c[i] & (a[i] ^ b_n[i]));
    end
  endgenerate

  assign cout = c[SLICE_W];

endmodule : sub_slice

`default_nettype wire

// File: rtl/sub_64_seq.sv
// ============================================================================
// Module      : sub_64_seq
// Description : Sequential 64-bit signed subtractor. An accepted start
//               latches A and ~B, then one SLICE_W-bit slice is processed per
//               BUSY cycle, LSB slice first. Result and flags are registered
//               and change only on the transition into DONE.
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset
//               start    - request, sampled in IDLE only
//               A, B     - signed minuend / subtrahend
//               busy     - high while in BUSY
//               done     - one-cycle pulse when results are valid
//               OUTPUT   - A - B
//               overflow - two's-complement overflow of A - B
//               zf, sf   - zero / sign flag of OUTPUT
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_64_seq
  import sub_64_seq_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] OUTPUT,
  output logic              overflow,
  output logic              zf,
  output logic              sf
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  // Keep the counter at least one bit wide for the single-slice case.
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);
  // Wide enough to hold DATA_W itself so the base multiply never wraps.
  localparam int BASE_W     = $clog2(DATA_W) + 1;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_n_q;       // subtrahend stored already inverted
  logic [DATA_W-1:0]   res_q;       // internal accumulator, never exported
  logic [DATA_W-1:0]   res_full;    // accumulator with the current slice merged
  logic [CNT_W-1:0]    cnt;
  logic                carry;
  logic [BASE_W-1:0]   base;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_cout;
  logic                last_slice;

  assign base       = BASE_W'(cnt) * BASE_W'(SLICE_W);
  assign last_slice = (cnt == LAST_SLICE);

  sub_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a    (a_q[base +: SLICE_W]),
    .b_n  (b_n_q[base +: SLICE_W]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // The complete result is only known in the last BUSY cycle; merge the
  // slice being produced so flags are taken from all 64 bits at once.
  always_comb begin
    res_full                   = res_q;
    res_full[base +: SLICE_W]  = slice_sum;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)      state_nxt = ST_BUSY;
      ST_BUSY: if (last_slice) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_n_q    <= '0;
      res_q    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      OUTPUT   <= '0;
      overflow <= 1'b0;
      zf       <= 1'b0;
      sf       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= A;
            b_n_q <= ~B;
            cnt   <= '0;
            carry <= 1'b1;   // +1 completes the two's complement of B
          end
        end
        ST_BUSY: begin
          res_q[base +: SLICE_W] <= slice_sum;
          carry                  <= slice_cout;
          cnt                    <= cnt + CNT_W'(1);
          if (last_slice) begin
            OUTPUT   <= res_full;
            // Operands of different sign and a result whose sign differs from
            // the minuend. b_n_q holds ~B, so "signs differ" means equal bits.
            overflow <= (a_q[DATA_W-1] == b_n_q[DATA_W-1]) &&
                        (res_full[DATA_W-1] != a_q[DATA_W-1]);
            zf       <= (res_full == '0);
            sf       <= res_full[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_BUSY);
  assign done = (state == ST_DONE);

endmodule : sub_64_seq

`default_nettype wire

// File: doc/sub_64_seq.md
SUB_64_SEQ -- requirements
Module: sub_64_seq

Interface
REQ-001 SHALL have parameter SLICE_W, default 8, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A  input  64  signed minuend; captured on the accepted start.
REQ-006 SHALL have port B  input  64  signed subtrahend; captured on the accepted start.
REQ-007 SHALL have port busy  output  1  high while in BUSY.
REQ-008 SHALL have port done  output  1  one-cycle pulse; the results are valid.
REQ-009 SHALL have port OUTPUT  output  64  signed result A-B.
REQ-010 SHALL have port overflow  output  1  two's-complement overflow of A-B.
REQ-011 SHALL have port zf  output  1  OUTPUT == 0.
REQ-012 SHALL have port sf  output  1  OUTPUT[63].

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL take these transitions: IDLE->BUSY on start=1; BUSY->DONE after the last slice; DONE->IDLE unconditionally.
REQ-015 On the accepted start, SHALL latch A and ~B into internal registers, set the slice counter to 0 and set the borrow-in carry register to 1.
REQ-016 Each BUSY cycle SHALL compute one SLICE_W-bit slice, LSB slice first: sum = Aslice + ~Bslice + carry.
REQ-017 Each BUSY cycle SHALL store the sum into the corresponding result bits, store the carry-out, and increment the counter.
REQ-018 BUSY SHALL last exactly 64/SLICE_W cycles.
REQ-019 With the default SLICE_W, done SHALL be high exactly 8 rising edges after the edge that sampled start, and for exactly one cycle.
REQ-020 overflow SHALL equal (A[63] != B[63]) && (OUTPUT[63] != A[63]), using the latched operands.
REQ-021 overflow SHALL NOT be derived from carry[64]^carry[63].
REQ-022 zf and sf SHALL be computed from the complete 64-bit result.
REQ-023 OUTPUT, overflow, zf and sf SHALL be registered.
REQ-024 OUTPUT, overflow, zf and sf SHALL update only on the transition into DONE.
REQ-025 OUTPUT, overflow, zf and sf SHALL hold their value until the next operation completes.
REQ-026 Partial slice results SHALL NOT be visible on OUTPUT during BUSY.
REQ-027 start during BUSY or DONE SHALL be ignored, not queued.
REQ-028 Changes on A and B after acceptance SHALL NOT affect the result in progress.
REQ-029 start held high continuously SHALL launch a new operation from each IDLE cycle, giving one result every 64/SLICE_W+2 cycles.
REQ-030 busy SHALL be high in BUSY only; done SHALL be high in DONE only; both SHALL never be high together.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, OUTPUT=0, overflow=0, zf=0, sf=0.
REQ-032 rst_n=0 SHALL immediately clear the counter, the carry register and the operand registers.
REQ-033 Reset during BUSY SHALL abort the operation, with no done pulse and no result update.
REQ-034 The first start after reset release SHALL be accepted normally.

Structure
REQ-035 The state encoding (IDLE/BUSY/DONE), the data width 64 and the default SLICE_W SHALL live in the shared ALU package.
REQ-036 The slice datapath SHALL be a separate sub-module, sub_slice: a SLICE_W-bit ripple of full-adder cells (A, ~B, cin -> sum, cout).
REQ-037 sub_64_seq SHALL contain only the FSM, counter, carry register, operand/result registers and flags.

Verification
REQ-038 After reset, A=5, B=3, start pulse -> done on edge 8: OUTPUT=2, overflow=0, zf=0, sf=0.
REQ-039 A=7, B=7 -> OUTPUT=0, zf=1, sf=0, overflow=0.
REQ-040 A=0, B=1 -> OUTPUT=0xFFFFFFFFFFFFFFFF, sf=1, overflow=0.
REQ-041 A=0x8000000000000000, B=1 -> OUTPUT=0x7FFFFFFFFFFFFFFF, overflow=1, sf=0.
REQ-042 A=0x7FFFFFFFFFFFFFFF, B=0xFFFFFFFFFFFFFFFF -> OUTPUT=0x8000000000000000, overflow=1, sf=1.
REQ-043 Start, then rst_n low at BUSY cycle 4 with start pulsed again during BUSY -> no done, all outputs 0, IDLE after release.
REQ-044 Start, then A/B changed mid-BUSY -> original result delivered; a random 10k-vector run SHALL match a reference A-B model.
